// File: rtl/sigmoid_pkg.sv
// Shared fixed-point definitions for the sigmoid forward and backward blocks.
// Q(WL-FL).FL two's complement; ONE is the fixed-point value 1.0.
package sigmoid_pkg;

  localparam int WL  = 16;
  localparam int FL  = 12;
  localparam int ONE = 1 << FL;

  typedef logic signed [WL-1:0]   q_t;
  typedef logic signed [2*WL-1:0] qq_t;

  localparam q_t ONE_Q  = q_t'(ONE);
  localparam q_t ZERO_Q = '0;

  // Clamp an activation into the unit interval [0, ONE].
  function automatic q_t clamp_unit(input q_t y);
    if (y < ZERO_Q)     return ZERO_Q;
    else if (y > ONE_Q) return ONE_Q;
    else                return y;
  endfunction

  // True when an activation lies outside [0, ONE].
  function automatic logic out_of_unit(input q_t y);
    return (y < ZERO_Q) || (y > ONE_Q);
  endfunction

  // Full-precision signed product of two Q words.
  function automatic qq_t mul_full(input q_t a, input q_t b);
    qq_t a_x;
    qq_t b_x;
    a_x = {{WL{a[WL-1]}}, a};
    b_x = {{WL{b[WL-1]}}, b};
    return a_x * b_x;
  endfunction

  // Rescale a double-width product back to Q: arithmetic shift rounds
  // toward minus infinity; callers guarantee the result fits WL bits.
  function automatic q_t floor_shift(input qq_t p);
    return q_t'(p >>> FL);
  endfunction

endpackage

// File: rtl/fx_mul_floor.sv
// Registered signed Q x Q multiply with floor rescale and clock enable.
// Output register holds its value while en_i is low.
module fx_mul_floor
  import sigmoid_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic signed [WL-1:0] a_i,
  input  logic signed [WL-1:0] b_i,
  output logic signed [WL-1:0] p_o
);

  q_t p_d;
  q_t p_q;

  assign p_d = floor_shift(mul_full(a_i, b_i));

  // Product register, advancing only with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/sigmoid_bwd.sv
// Sigmoid backward pass: grad_out = g * y * (1 - y), 3-stage valid/ready
// pipeline with a single global advance (all stages move or all hold).
//   S1: clamp y to [0, ONE], form 1-y, capture g
//   S2: d = floor(yc * (ONE - yc) / ONE)
//   S3: r = floor(g * d / ONE)
module sigmoid_bwd
  import sigmoid_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WL-1:0] act_in,
  input  logic signed [WL-1:0] grad_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] grad_out,
  output logic                 clamp_flag,
  input  logic                 clamp_clr
);

  logic adv;
  logic accept;

  q_t   yc_d, om_d;
  q_t   yc_q, om_q, g1_q;
  logic v1_q;

  q_t   d_q, g2_q;
  logic v2_q;

  logic out_valid_q;
  logic clamp_flag_d, clamp_flag_q;

  // Advance whenever the output slot is empty or being drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // S1 operands: clamped activation and its complement.
  always_comb begin
    yc_d = clamp_unit(act_in);
    om_d = ONE_Q - yc_d;
  end

  // Stage 1 registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would leak one stage into the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too so grad_out reads 0 after reset;
      // the valids alone are what discard in-flight transactions.
      v1_q <= 1'b0;
      yc_q <= '0;
      om_q <= '0;
      g1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      yc_q <= yc_d;
      om_q <= om_d;
      g1_q <= grad_in;
    end
  end

  // S2 product d = yc*(1-yc); never exceeds ONE/4, so it fits WL.
  fx_mul_floor u_s2_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .a_i   (yc_q),
    .b_i   (om_q),
    .p_o   (d_q)
  );

  // Stage 2 side-band: gradient and valid travel alongside d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      g2_q <= '0;
    end else if (adv) begin
      v2_q <= v1_q;
      g2_q <= g1_q;
    end
  end

  // S3 product r = g*d; |r| <= |g|/4, so truncation to WL is exact.
  fx_mul_floor u_s3_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .a_i   (g2_q),
    .b_i   (d_q),
    .p_o   (grad_out)
  );

  // Output valid; holds with grad_out while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= v2_q;
    end
  end

  assign out_valid = out_valid_q;

  // Sticky out-of-range flag; clear has priority over a same-cycle set.
  always_comb begin
    clamp_flag_d = clamp_flag_q;
    if (clamp_clr) begin
      clamp_flag_d = 1'b0;
    end else if (accept && out_of_unit(act_in)) begin
      clamp_flag_d = 1'b1;
    end
  end

  // Clamp flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_flag_q <= 1'b0;
    end else begin
      clamp_flag_q <= clamp_flag_d;
    end
  end

  assign clamp_flag = clamp_flag_q;

endmodule

// File: tb/tb_sigmoid_bwd.sv
// Self-checking bench for sigmoid_bwd: directed corner cases plus randomized
// traffic compared in order against an arithmetic reference model.
module tb_sigmoid_bwd;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] act_in = '0;
  logic signed [15:0] grad_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] grad_out;
  logic               clamp_flag;
  logic               clamp_clr = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];

  sigmoid_bwd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .act_in     (act_in),
    .grad_in    (grad_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grad_out   (grad_out),
    .clamp_flag (clamp_flag),
    .clamp_clr  (clamp_clr)
  );

  always #5 clk = ~clk;

  // Reference: clamp y, d = floor(yc*(1-yc)), r = floor(g*d), all in
  // plain integer arithmetic with ONE = 4096.
  function automatic int ref_grad(input int y, input int g);
    int     yc;
    longint d, n, r;
    yc = (y < 0) ? 0 : ((y > 4096) ? 4096 : y);
    d  = (longint'(yc) * longint'(4096 - yc)) / 4096;
    n  = longint'(g) * d;
    r  = n / 4096;
    if ((n % 4096) != 0 && n < 0) r = r - 1;
    return int'(r);
  endfunction

  // One clock of stimulus: drive at negedge, sample after settling, record
  // accepted inputs in the expected queue, then release pulses.
  task automatic step(input bit iv, input int y, input int g, input bit ordy,
                      input bit clr, output bit irdy, output bit ov,
                      output int gout);
    @(negedge clk);
    in_valid  = iv;
    act_in    = 16'(y);
    grad_in   = 16'(g);
    out_ready = ordy;
    clamp_clr = clr;
    #1;
    irdy = in_ready;
    ov   = out_valid;
    gout = int'(grad_out);
    if (iv && irdy) exp_q.push_back(ref_grad(y, g));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clamp_clr = 1'b0;
  endtask

  // One isolated transaction: checks acceptance, 3-cycle latency and value.
  task automatic run_single(input string name, input int y, input int g,
                            input int expv);
    bit irdy, ov;
    int gout;
    int lat;
    bit seen;
    step(1'b1, y, g, 1'b1, 1'b0, irdy, ov, gout);
    vectors++;
    if (irdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%0b required 1", name, irdy);
    end
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0, irdy, ov, gout);
      if (ov) begin
        seen = 1'b1;
        lat  = k;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        vectors++;
        if (lat != 3) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles required 3", name, lat);
        end
        vectors++;
        if (gout != expv) begin
          errors++;
          $display("FAIL %s_value: grad_out=%0d required %0d", name, gout, expv);
        end
      end
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: no out_valid within 8 cycles", name);
    end
  endtask

  // Idle with out_ready high until the expected queue is empty.
  task automatic drain(input string name);
    bit irdy, ov;
    int gout;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0, irdy, ov, gout);
      if (ov) begin
        vectors++;
        if (gout != exp_q[0]) begin
          errors++;
          $display("FAIL %s_drain: grad_out=%0d required %0d", name, gout, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d outputs missing", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (out_valid !== 1'b0 || grad_out !== 16'sd0 || clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%0b grad_out=%0d clamp_flag=%0b required 0/0/0",
               out_valid, grad_out, clamp_flag);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_single("half", 2048, 4096, 1024);
    run_single("y1000", 1000, 4096, 755);
    run_single("neg_min_g", 2048, -32768, -8192);
    run_single("y1000_neg", 1000, -4096, -755);
  endtask

  task automatic test_boundaries();
    run_single("y_zero", 0, 4096, 0);
    run_single("y_one", 4096, 4096, 0);
    vectors++;
    if (clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL bound_flag: clamp_flag=%0b required 0", clamp_flag);
    end
  endtask

  task automatic test_clamp();
    bit irdy, ov;
    int gout;
    run_single("y_neg", -100, 4096, 0);
    vectors++;
    if (clamp_flag !== 1'b1) begin
      errors++;
      $display("FAIL clamp_set_low: clamp_flag=%0b required 1", clamp_flag);
    end
    run_single("y_big", 5000, 4096, 0);
    vectors++;
    if (clamp_flag !== 1'b1) begin
      errors++;
      $display("FAIL clamp_set_high: clamp_flag=%0b required 1", clamp_flag);
    end
    step(1'b0, 0, 0, 1'b1, 1'b1, irdy, ov, gout);
    vectors++;
    if (clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL clamp_clear: clamp_flag=%0b required 0", clamp_flag);
    end
    step(1'b1, -100, 4096, 1'b1, 1'b1, irdy, ov, gout);
    vectors++;
    if (clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL clamp_clr_wins: clamp_flag=%0b required 0", clamp_flag);
    end
    drain("clamp");
  endtask

  // Random in_valid / out_ready mix, wide y range including out-of-range.
  task automatic test_random();
    bit irdy, ov, iv, ordy;
    int y, g, gout;
    for (int k = 0; k < 200; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      y    = int'($urandom_range(0, 5119)) - 512;
      g    = int'($signed(16'($urandom)));
      step(iv, y, g, ordy, 1'b0, irdy, ov, gout);
      if (ov && ordy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra: unexpected grad_out=%0d", gout);
        end else begin
          if (gout != exp_q[0]) begin
            errors++;
            $display("FAIL random_value: grad_out=%0d required %0d", gout, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    drain("random");
  endtask

  task automatic test_back_to_back();
    bit irdy, ov, ordy, iv;
    bit prev_stall;
    int prev_gout;
    int y, g, gout;
    int sent, received;
    sent = 0;
    received = 0;
    prev_stall = 1'b0;
    prev_gout = 0;
    y = int'($urandom_range(0, 4096));
    g = int'($signed(16'($urandom)));
    for (int k = 0; k < 120 && received < 16; k++) begin
      iv   = (sent < 16);
      ordy = !(k >= 6 && k < 11);
      step(iv, y, g, ordy, 1'b0, irdy, ov, gout);
      vectors++;
      if (irdy !== !(ov && !ordy)) begin
        errors++;
        $display("FAIL b2b_in_ready: cycle %0d in_ready=%0b required %0b",
                 k, irdy, !(ov && !ordy));
      end
      if (prev_stall) begin
        vectors++;
        if (!ov || gout != prev_gout) begin
          errors++;
          $display("FAIL b2b_stable: cycle %0d out_valid=%0b grad_out=%0d required 1/%0d",
                   k, ov, gout, prev_gout);
        end
      end
      prev_stall = ov && !ordy;
      prev_gout  = gout;
      if (iv && irdy) begin
        sent++;
        y = int'($urandom_range(0, 4096));
        g = int'($signed(16'($urandom)));
      end
      if (ov && ordy) begin
        vectors++;
        received++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected grad_out=%0d", gout);
        end else begin
          if (gout != exp_q[0]) begin
            errors++;
            $display("FAIL b2b_value: output %0d grad_out=%0d required %0d",
                     received, gout, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    vectors++;
    if (received != 16) begin
      errors++;
      $display("FAIL b2b_count: received %0d required 16", received);
    end
  endtask

  // Reset while the pipeline is full: outputs drop at once, nothing stale after.
  task automatic test_reset_mid_burst();
    bit irdy, ov;
    int gout;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1000 + k, 4096, 1'b1, 1'b0, irdy, ov, gout);
    end
    @(negedge clk);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || grad_out !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_outputs: out_valid=%0b grad_out=%0d required 0/0",
               out_valid, grad_out);
    end
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0, irdy, ov, gout);
      vectors++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale: cycle %0d out_valid=%0b required 0", k, ov);
      end
    end
    run_single("post_reset", 2048, 4096, 1024);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_clamp();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
